actuator_scheduler: RTL and testbench
=====================================

// Module: actuator_scheduler
// PURPOSE
//  Time-slices one shared actuator driver between the three alarm/actuator channels H, DC, C.
//  Inputs are the per-channel demand lines produced by the alarm FSM (AAH/AADC/AAC).
//  Outputs are one-hot driver grants with round-robin fairness and break-before-make dead time.
//  Sits between the alarm FSM and the physical driver stage.
// PARAMETERS
//  SLICE     4  grant length in cycles while another channel waits (>=1)
//  DEAD_CYC  2  all-grants-low gap between two different grants (>=1)
// PORTS
//  CLK      in   1  system clock, rising edge
//  reset_n  in   1  asynchronous active-low reset
//  enable   in   1  scheduler enable; low forces release
//  req      in   3  demand: [0]=H, [1]=DC, [2]=C; level, sampled every cycle
//  grant    out  3  one-hot driver select, same bit order; registered
//  busy     out  1  high in GRANT or DEAD; registered
//  cur_ch   out  2  index of granted channel (0/1/2); 3 when none
// BEHAVIOUR
//  Reset: grant=0, busy=0, cur_ch=3, state IDLE, RR pointer last=C (first winner H).
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  All outputs are decoded from registers: no combinational path from req to grant.
//  FSM states IDLE, GRANT, DEAD; slice/dead counter width $clog2(max(SLICE,DEAD_CYC)+1).
//  RR pick: first requesting channel after `last` in order H->DC->C->H. The winner updates `last`.
//  IDLE
//   - enable & |req: pick winner, load counter SLICE-1, go to GRANT.
//   - grant rises on that same edge: 1-cycle latency from req sampled.
//  GRANT (grant[ch]=1)
//   - ~enable or ~req[ch]: go to DEAD immediately; grant falls on the next edge.
//   - counter==0 and another channel requesting: go to DEAD.
//   - counter==0 and only ch requesting: reload SLICE-1 and stay; no gap, no glitch.
//   - else decrement.
//  DEAD (grant=0)
//   - Lasts exactly DEAD_CYC cycles.
//   - Then, if enable & |req: RR pick, go to GRANT. Otherwise go to IDLE.
//  Guarantees
//   - Never more than one grant bit high.
//   - A grant change always has >=DEAD_CYC zero cycles between grants.
//  Boundaries
//   - Request arriving during DEAD waits for DEAD to end.
//   - Request re-raised by the just-released channel during DEAD is honoured only if no other channel requests.
//   - enable low holds IDLE and does not move `last`.
//   - Reset mid-grant: grant=0 asynchronously; RR pointer returns to last=C.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds out ports gcnt_h, gcnt_dc, gcnt_c (16 b each).
//   - Each is a saturating count of GRANT entries for its channel.
//   - Increments on the entry edge, never on a slice reload.
//   - Cleared by reset; holds at 16'hFFFF.
//  SCHED_STATS_EN not defined: ports and counters absent; scheduling behaviour identical.
// STRUCTURE
//  Shared package sched_pkg:
//   - state encoding IDLE/GRANT/DEAD.
//   - channel index constants CH_H=0, CH_DC=1, CH_C=2, CH_NONE=3.
//  Sub-module rr_next_pick: combinational (req[2:0], last[1:0]) -> (valid, idx[1:0]).
//  Everything else is in actuator_scheduler.
// TESTING (SLICE=4, DEAD_CYC=2)
//  1. Reset
//     - Stimulus: reset_n low, with req=3'b111.
//     - Required: grant=0, busy=0, cur_ch=3 throughout reset.
//     - After release: grant=3'b001 one edge later.
//  2. All request
//     - Stimulus: req=3'b111 held.
//     - Required: grant 001 x4, 000 x2, 010 x4, 000 x2, 100 x4, 000 x2, then 001 again.
//  3. Single channel held
//     - Stimulus: only req[1] held 20 cycles.
//     - Required: grant=010 continuously for all 20 cycles, no zero gaps.
//  4. Early drop
//     - Stimulus: req=001, then req[0] dropped after 2 grant cycles, while req[2]=1.
//     - Required: grant 001 x2, 000 x2, 100.
//  5. Enable low / reset mid-grant
//     - Stimulus: enable low in GRANT.
//     - Required: grant=0 next edge, busy stays high for DEAD_CYC, then 0.
//     - Stimulus: reset_n pulse in GRANT.
//     - Required: grant=0 immediately; after release the next winner is H.
//  6. Stats (SCHED_STATS_EN)
//     - Stimulus: scenario 2 run for 3 full rotations.
//     - Required: gcnt_h=gcnt_dc=gcnt_c=3.
//     - Stimulus: scenario 3 run.
//     - Required: gcnt_dc increments by 1 only.

Source files
------------

// File: rtl/actuator_scheduler_pkg.sv
// actuator_scheduler_pkg: shared FSM state encoding, channel indices and round-robin helper for actuator_scheduler
//  Contents: state_t (IDLE/GRANT/DEAD), CH_H/CH_DC/CH_C/CH_NONE, next_ch()
package sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_t;
  localparam logic [1:0] CH_H = 2'd0;
  localparam logic [1:0] CH_DC = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;
  function automatic logic [1:0] next_ch(logic [1:0] ch);
    return ch == CH_H ? CH_DC : ch == CH_DC ? CH_C : CH_H;
  endfunction
endpackage

// File: rtl/actuator_scheduler_if.sv
// actuator_scheduler_if: demand/grant bundle between alarm FSM (master) and actuator_scheduler (slave)
//  enable, req[2:0] : master -> scheduler
//  grant[2:0], busy, cur_ch[1:0] : scheduler -> master
//  SCHED_STATS_EN adds gcnt_h, gcnt_dc, gcnt_c[15:0] : scheduler -> master
interface actuator_scheduler_if;
  logic enable;
  logic [2:0] req;
  logic [2:0] grant;
  logic busy;
  logic [1:0] cur_ch;
`ifdef SCHED_STATS_EN
  logic [15:0] gcnt_h;
  logic [15:0] gcnt_dc;
  logic [15:0] gcnt_c;
  modport master (output enable, req, input grant, busy, cur_ch, gcnt_h, gcnt_dc, gcnt_c);
  modport slave (input enable, req, output grant, busy, cur_ch, gcnt_h, gcnt_dc, gcnt_c);
`else
  modport master (output enable, req, input grant, busy, cur_ch);
  modport slave (input enable, req, output grant, busy, cur_ch);
`endif
endinterface

// File: rtl/actuator_scheduler_rr_next_pick.sv
// rr_next_pick: combinational round-robin pick of the first requester after last, order H->DC->C->H
//  req[2:0], last[1:0] in; valid (any request), idx[1:0] (CH_NONE when no request) out
module rr_next_pick
  import sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);
  logic [1:0] a, b, c;
  assign a = next_ch(last);
  assign b = next_ch(a);
  assign c = next_ch(b);
  assign valid = |req;
  assign idx = req[a] ? a : req[b] ? b : req[c] ? c : CH_NONE;
endmodule

// File: rtl/actuator_scheduler.sv
// actuator_scheduler: round-robin time-slicing of one actuator driver across H/DC/C with break-before-make dead time
//  CLK, reset_n (async active-low); bus: actuator_scheduler_if.slave (enable, req in; grant, busy, cur_ch out)
//  Parameters: SLICE grant length while others wait, DEAD_CYC zero-grant gap between grants
//  SCHED_STATS_EN: adds saturating per-channel GRANT-entry counters on bus.gcnt_*
module actuator_scheduler
  import sched_pkg::*;
#(
  parameter int SLICE = 4,
  parameter int DEAD_CYC = 2
) (
  input logic CLK,
  input logic reset_n,
  actuator_scheduler_if.slave bus
);
  localparam int CW = $clog2((SLICE > DEAD_CYC ? SLICE : DEAD_CYC) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] last, pick_idx, ch_q;
  logic [2:0] grant_q;
  logic busy_q, pick_valid, enter, drop;
  rr_next_pick u_pick (.req(bus.req), .last(last), .valid(pick_valid), .idx(pick_idx));
  // New grants only start from IDLE or at the last DEAD cycle, so every handover sees the full gap.
  assign enter = bus.enable && pick_valid && (state == IDLE || (state == DEAD && cnt == '0));
  assign drop = state == GRANT && (!bus.enable || !(|(bus.req & grant_q)) || (cnt == '0 && |(bus.req & ~grant_q)));
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= CH_C;
      grant_q <= '0;
      busy_q <= 1'b0;
      ch_q <= CH_NONE;
    end else if (enter) begin
      state <= GRANT;
      cnt <= CW'(SLICE - 1);
      last <= pick_idx;
      grant_q <= 3'b001 << pick_idx;
      busy_q <= 1'b1;
      ch_q <= pick_idx;
    end else if (drop) begin
      state <= DEAD;
      cnt <= CW'(DEAD_CYC - 1);
      grant_q <= '0;
      ch_q <= CH_NONE;
    end else if (state == DEAD && cnt == '0) begin
      state <= IDLE;
      busy_q <= 1'b0;
    end else if (state != IDLE) begin
      cnt <= cnt == '0 ? CW'(SLICE - 1) : cnt - 1'b1;
    end
  end
  assign bus.grant = grant_q;
  assign bus.busy = busy_q;
  assign bus.cur_ch = ch_q;
`ifdef SCHED_STATS_EN
  logic [15:0] gcnt [3];
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      gcnt[0] <= '0;
      gcnt[1] <= '0;
      gcnt[2] <= '0;
    end else if (enter && gcnt[pick_idx] != 16'hFFFF) begin
      gcnt[pick_idx] <= gcnt[pick_idx] + 16'd1;
    end
  end
  assign bus.gcnt_h = gcnt[0];
  assign bus.gcnt_dc = gcnt[1];
  assign bus.gcnt_c = gcnt[2];
`endif
endmodule

// File: tb/tb_actuator_scheduler.sv
// tb_actuator_scheduler: directed table-driven bench for actuator_scheduler (SLICE=4, DEAD_CYC=2)
module tb_actuator_scheduler;
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic en;
    logic [2:0] req;
    logic [2:0] g;
    logic b;
    logic [1:0] ch;
  } vec_t;
  vec_t tv[$];
  actuator_scheduler_if bus();
  actuator_scheduler #(.SLICE(4), .DEAD_CYC(2)) dut (.CLK(CLK), .reset_n(reset_n), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(logic en, logic [2:0] r, logic [2:0] g, logic b, logic [1:0] ch);
    tv.push_back('{en, r, g, b, ch});
  endfunction
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  always @(negedge CLK) begin
    if (reset_n) begin
      checks++;
      if ($countones(bus.grant) > 1) begin
        errors++;
        $display("FAIL onehot: got %b expected at most one bit", bus.grant);
      end
    end
  end
  initial begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        repeat (4) add(1, 3'b111, 3'(1 << c), 1, 2'(c));
        repeat (2) add(1, 3'b111, 3'b000, 1, 2'd3);
      end
    end
    add(1, 3'b111, 3'b001, 1, 0);
    repeat (2) add(1, 3'b010, 3'b000, 1, 3);
    repeat (20) add(1, 3'b010, 3'b010, 1, 1);
    repeat (2) add(1, 3'b000, 3'b000, 1, 3);
    add(1, 3'b000, 3'b000, 0, 3);
    add(1, 3'b001, 3'b001, 1, 0);
    add(1, 3'b101, 3'b001, 1, 0);
    repeat (2) add(1, 3'b100, 3'b000, 1, 3);
    add(1, 3'b100, 3'b100, 1, 2);
    repeat (2) add(0, 3'b100, 3'b000, 1, 3);
    repeat (2) add(0, 3'b100, 3'b000, 0, 3);
    repeat (4) add(1, 3'b111, 3'b001, 1, 0);
    repeat (2) add(1, 3'b111, 3'b000, 1, 3);
    add(1, 3'b111, 3'b010, 1, 1);
    bus.enable = 1'b1;
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset grant", 16'(bus.grant), 0);
      chk("reset busy", 16'(bus.busy), 0);
      chk("reset cur_ch", 16'(bus.cur_ch), 3);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    foreach (tv[i]) begin
      bus.enable = tv[i].en;
      bus.req = tv[i].req;
      step();
      chk($sformatf("vec%0d grant", i), 16'(bus.grant), 16'(tv[i].g));
      chk($sformatf("vec%0d busy", i), 16'(bus.busy), 16'(tv[i].b));
      chk($sformatf("vec%0d cur_ch", i), 16'(bus.cur_ch), 16'(tv[i].ch));
    end
    #3;
    reset_n = 1'b0;
    #1;
    chk("midreset grant", 16'(bus.grant), 0);
    chk("midreset busy", 16'(bus.busy), 0);
    chk("midreset cur_ch", 16'(bus.cur_ch), 3);
    @(negedge CLK);
    reset_n = 1'b1;
    step();
    chk("post-reset winner", 16'(bus.grant), 16'(3'b001));
    repeat (53) step();
    chk("rotation end grant", 16'(bus.grant), 0);
    chk("rotation end busy", 16'(bus.busy), 1);
    bus.req = 3'b000;
    repeat (4) step();
    chk("idle after drop", 16'(bus.busy), 0);
`ifdef SCHED_STATS_EN
    chk("gcnt_h rot", bus.gcnt_h, 3);
    chk("gcnt_dc rot", bus.gcnt_dc, 3);
    chk("gcnt_c rot", bus.gcnt_c, 3);
`endif
    bus.req = 3'b010;
    repeat (25) step();
    chk("dc held grant", 16'(bus.grant), 16'(3'b010));
`ifdef SCHED_STATS_EN
    chk("gcnt_h held", bus.gcnt_h, 3);
    chk("gcnt_dc held", bus.gcnt_dc, 4);
    chk("gcnt_c held", bus.gcnt_c, 3);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
